// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data memory request/response bus between the MEM stage and data memory
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, mask, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, mask, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage running loads/stores on the data memory bus with alignment checks and a watchdog
module mem_access_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_funct3,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_store_data,
    mem_access_stage_if.master dmem,
    output logic               o_stall,
    output logic [31:0]        o_mem_data_out,
    output logic               o_done,
    output logic               o_misalign,
    output logic               o_bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] wd_cnt;
    logic [29:0]   word_q;
    logic [1:0]    off_q;
    logic [2:0]    funct3_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    mask_q;
    logic          access, aligned, start, complete, capture, timeout;
    logic [31:0]   shifted, load_val;

    assign access   = i_valid & (i_mem_read | i_mem_write);
    assign aligned  = i_funct3[1] ? (i_addr[1:0] == 2'b00) : (i_funct3[0] ? !i_addr[0] : 1'b1);
    assign start    = access & aligned;
    assign shifted  = dmem.rdata >> {off_q, 3'b000};
    assign load_val = funct3_q[1] ? shifted :
                      funct3_q[0] ? {{16{!funct3_q[2] & shifted[15]}}, shifted[15:0]} :
                                    {{24{!funct3_q[2] & shifted[7]}}, shifted[7:0]};

    assign dmem.req   = state_q == REQ;
    assign dmem.we    = we_q;
    assign dmem.addr  = {word_q, 2'b00};
    assign dmem.wdata = wdata_q;
    assign dmem.mask  = mask_q;

    // next state, completion/timeout decisions and the pipeline stall
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ: if (dmem.ready) begin
                complete = we_q | dmem.rvalid;
                capture  = !we_q & dmem.rvalid;
                state_d  = WAIT;
            end
            WAIT: begin
                complete = dmem.rvalid;
                capture  = dmem.rvalid;
            end
            default: state_d = IDLE;
        endcase
        timeout = (MAX_WAIT != 0) && (state_q != IDLE) && !complete && (wd_cnt == WD_LAST);
        if (complete || timeout) state_d = IDLE;
        o_stall = (state_q == IDLE) ? start : !(complete || timeout);
    end

    // state register; reset drops the request immediately
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // request latch, watchdog counter and registered result/pulses
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wd_cnt         <= '0;
            word_q         <= '0;
            off_q          <= '0;
            funct3_q       <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            mask_q         <= '0;
            o_mem_data_out <= '0;
            o_done         <= 1'b0;
            o_misalign     <= 1'b0;
            o_bus_err      <= 1'b0;
        end else begin
            wd_cnt     <= (state_q == IDLE) ? '0 : wd_cnt + 1'b1;
            o_done     <= complete;
            o_misalign <= (state_q == IDLE) && access && !aligned;
            o_bus_err  <= timeout;
            if (state_q == IDLE && start) begin
                word_q   <= i_addr[31:2];
                off_q    <= i_addr[1:0];
                funct3_q <= i_funct3;
                we_q     <= i_mem_write;
                wdata_q  <= i_store_data << {i_addr[1:0], 3'b000};
                mask_q   <= i_funct3[1] ? 4'b1111 : (i_funct3[0] ? 4'b0011 : 4'b0001) << i_addr[1:0];
            end
            if (capture)      o_mem_data_out <= load_val;
            else if (timeout) o_mem_data_out <= '0;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of the MEM stage against a transaction-level model
module tb_mem_access_stage;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, mrd = 1'b0, mwr = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0, sdata = '0;
    logic        stall, done, mis, berr;
    logic [31:0] mdata;
    int          checks = 0, errors = 0;
    logic [2:0]  f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    mem_access_stage_if bus();

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_mem_read(mrd), .i_mem_write(mwr),
        .i_funct3(f3), .i_addr(addr), .i_store_data(sdata), .dmem(bus.master),
        .o_stall(stall), .o_mem_data_out(mdata), .o_done(done), .o_misalign(mis), .o_bus_err(berr)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic int size_of(logic [2:0] f);
        return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] extract(logic [2:0] f, logic [31:0] a, logic [31:0] w);
        logic [31:0] s;
        int v;
        s = w >> (8 * int'(a[1:0]));
        if (size_of(f) == 4) return w;
        if (size_of(f) == 1) v = f[2] ? int'(s[7:0]) : int'($signed(s[7:0]));
        else                 v = f[2] ? int'(s[15:0]) : int'($signed(s[15:0]));
        return v;
    endfunction

    typedef struct {
        bit          active;
        bit          accepted;
        bit          we;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [2:0]  f3;
        int          age;
    } txn_t;

    txn_t        m;
    logic [31:0] m_data = '0;
    bit          m_done = 0, m_mis = 0, m_berr = 0;

    // transaction-level model, compared against the DUT every cycle
    always @(negedge clk) begin : model
        bit acc, al, fin, tmo;
        int sz, off;
        #2;
        if (!rst_n) begin
            m = '{active: 0, accepted: 0, we: 0, addr: '0, sd: '0, f3: '0, age: 0};
            m_data = '0; m_done = 0; m_mis = 0; m_berr = 0;
            chk("rst_req", 32'(bus.req), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_mis", 32'(mis), 0);
            chk("rst_berr", 32'(berr), 0);
            chk("rst_data", mdata, 0);
        end else begin
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_mis", 32'(mis), 32'(m_mis));
            chk("m_berr", 32'(berr), 32'(m_berr));
            chk("m_data", mdata, m_data);
            acc = valid && (mrd || mwr);
            sz  = size_of(f3);
            al  = (addr % sz) == 0;
            fin = m.active && (m.accepted ? bus.rvalid : bus.ready && (m.we || bus.rvalid));
            tmo = m.active && !fin && (m.age + 1 == MAXW);
            chk("m_req", 32'(bus.req), 32'(m.active && !m.accepted));
            chk("m_stall", 32'(stall), 32'(m.active ? (!fin && !tmo) : (acc && al)));
            if (m.active && !m.accepted) begin
                off = int'(m.addr % 4);
                chk("m_addr", bus.addr, m.addr - 32'(off));
                chk("m_we", 32'(bus.we), 32'(m.we));
                chk("m_mask", 32'(bus.mask), 32'(((1 << size_of(m.f3)) - 1) << off));
                chk("m_wdata", bus.wdata, m.sd << (8 * off));
            end
            m_done = fin;
            m_berr = tmo;
            m_mis  = !m.active && acc && !al;
            if (fin && !m.we) m_data = extract(m.f3, m.addr, bus.rdata);
            if (tmo) m_data = '0;
            if (m.active) begin
                if (fin || tmo) m.active = 0;
                else begin
                    m.accepted = m.accepted || bus.ready;
                    m.age++;
                end
            end else if (acc && al) begin
                m = '{active: 1, accepted: 0, we: mwr, addr: addr, sd: sdata, f3: f3, age: 0};
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(bit v, bit r, bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
        valid = v; mrd = r; mwr = w; f3 = f; addr = a; sdata = d;
    endtask

    task automatic mem(bit rdy, bit rv, logic [31:0] rd);
        bus.ready = rdy; bus.rvalid = rv; bus.rdata = rd;
    endtask

    // start, then ready (and rvalid for loads) on the first request cycle
    task automatic access_fast(bit we, logic [2:0] f, logic [31:0] a, logic [31:0] sd, logic [31:0] rd);
        tick(); drive(1, !we, we, f, a, sd); mem(0, 0, 0);
        #3 chk("fast_stall_start", 32'(stall), 1);
        chk("fast_req_start", 32'(bus.req), 0);
        tick(); mem(1, !we, rd);
        #3 chk("fast_req", 32'(bus.req), 1);
        chk("fast_addr", bus.addr, {a[31:2], 2'b00});
        chk("fast_stall_done", 32'(stall), 0);
        tick(); drive(0, 0, 0, 0, 0, 0); mem(0, 0, 0);
        #3 chk("fast_done", 32'(done), 1);
        chk("fast_req_after", 32'(bus.req), 0);
    endtask

    initial begin
        mem(0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        #3 chk("reset_data", mdata, 0);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_done", 32'(done), 0);

        access_fast(0, 3'b010, 32'h100, 0, 32'hDEADBEEF);
        chk("lw_data", mdata, 32'hDEADBEEF);
        tick(); #3 chk("lw_done_pulse", 32'(done), 0);

        access_fast(0, 3'b000, 32'h103, 0, 32'h80FF_0000);
        chk("lb_data", mdata, 32'hFFFFFF80);
        access_fast(0, 3'b100, 32'h103, 0, 32'h80FF_0000);
        chk("lbu_data", mdata, 32'h00000080);
        access_fast(0, 3'b101, 32'h102, 0, 32'h80FF_0000);
        chk("lhu_data", mdata, 32'h000080FF);

        tick(); drive(1, 0, 1, 3'b000, 32'h201, 32'hAB); mem(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #3 chk("sb_req", 32'(bus.req), 1);
            chk("sb_mask", 32'(bus.mask), 32'h2);
            chk("sb_wdata", bus.wdata, 32'h0000AB00);
            chk("sb_we", 32'(bus.we), 1);
            chk("sb_addr", bus.addr, 32'h200);
            chk("sb_stall", 32'(stall), 1);
        end
        tick(); mem(1, 0, 0);
        #3 chk("sb_stall_done", 32'(stall), 0);
        tick(); drive(0, 0, 0, 0, 0, 0); mem(0, 0, 0);
        #3 chk("sb_done", 32'(done), 1);
        chk("sb_berr", 32'(berr), 0);
        chk("sb_keeps_data", mdata, 32'h000080FF);

        tick(); drive(1, 1, 0, 3'b010, 32'h102, 0);
        #3 chk("lw_mis_stall", 32'(stall), 0);
        chk("lw_mis_req", 32'(bus.req), 0);
        tick(); drive(0, 0, 0, 0, 0, 0);
        #3 chk("lw_mis_pulse", 32'(mis), 1);
        chk("lw_mis_noreq", 32'(bus.req), 0);
        tick(); drive(1, 0, 1, 3'b001, 32'h3, 32'h1234);
        #3 chk("mis_clear", 32'(mis), 0);
        chk("sh_mis_stall", 32'(stall), 0);
        tick(); drive(0, 0, 0, 0, 0, 0);
        #3 chk("sh_mis_pulse", 32'(mis), 1);
        chk("sh_mis_noreq", 32'(bus.req), 0);

        tick(); drive(1, 1, 0, 3'b010, 32'h40, 0); mem(0, 0, 0);
        for (int i = 0; i < MAXW; i++) begin
            tick();
            #3 chk("wd_req", 32'(bus.req), 1);
            chk("wd_stall", 32'(stall), (i == MAXW - 1) ? 0 : 1);
        end
        tick(); drive(0, 0, 0, 0, 0, 0);
        #3 chk("wd_berr", 32'(berr), 1);
        chk("wd_done", 32'(done), 0);
        chk("wd_data", mdata, 0);
        chk("wd_req_off", 32'(bus.req), 0);
        chk("wd_stall_off", 32'(stall), 0);

        access_fast(0, 3'b010, 32'h0, 0, 32'h12345678);
        chk("pre_rst_data", mdata, 32'h12345678);

        tick(); drive(1, 1, 0, 3'b010, 32'h10, 0); mem(0, 0, 0);
        tick(); mem(1, 0, 0);
        tick(); mem(0, 0, 0);
        #3 chk("wait_req", 32'(bus.req), 0);
        chk("wait_stall", 32'(stall), 1);
        tick(); drive(0, 0, 0, 0, 0, 0); rst_n = 1'b0;
        #1 chk("rst_async_data", mdata, 0);
        tick();
        tick(); rst_n = 1'b1;
        tick(); mem(0, 1, 32'hCAFEF00D);
        tick(); mem(0, 0, 0);
        #3 chk("late_rvalid_done", 32'(done), 0);
        chk("late_rvalid_data", mdata, 0);
        chk("late_rvalid_stall", 32'(stall), 0);

        tick(); drive(1, 1, 0, 3'b010, 32'h20, 0);
        tick();
        #3 chk("req_before_rst", 32'(bus.req), 1);
        rst_n = 1'b0;
        #1 chk("req_async_drop", 32'(bus.req), 0);
        tick(); drive(0, 0, 0, 0, 0, 0);
        tick(); rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            int op;
            logic [2:0] f;
            logic [31:0] a;
            tick();
            rst_n = ($urandom_range(0, 399) != 0);
            op = $urandom_range(0, 3);
            f = f3s[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f) - 1);
            drive($urandom_range(0, 9) < 7, op == 0 || op == 2, op == 1 || op == 2, f, a, $urandom);
            mem($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom);
        end
        tick(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0); mem(0, 0, 0);
        repeat (8) tick();
        #3 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
